dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder on the far side of the RV32 core's load/store port.
- Accepts word address, per-byte write strobes and four write-data byte lanes from the core; returns 32-bit read data one cycle later.
- After reset, an internal FSM zero-fills the array before accepting accesses.
- Flags and counts accesses outside its address window.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words; power of two, at least 4.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_addr  input  32  byte address from core; bits [1:0] ignored.
- datamem_wr  input  4  byte-lane write strobes; bit i writes lane i.
- data_in0  input  8  write byte lane 0, bits [7:0] of the word.
- data_in1  input  8  write byte lane 1, bits [15:8].
- data_in2  input  8  write byte lane 2, bits [23:16].
- data_in3  input  8  write byte lane 3, bits [31:24].
- data_out  output  32  registered read data to the core.
- mem_ready  output  1  high once zero-fill is complete.
- err  output  1  one-cycle pulse on an out-of-window access.
- err_cnt  output  ERR_W  saturating count of out-of-window accesses.

Behaviour:
- Reset (asynchronous, rst=1):
  - data_out=0, mem_ready=0, err=0, err_cnt=0.
  - FSM forced to CLEAR, clear index=0.
  - Array contents are not reset; the FSM zero-fills them.
- Window hit: BASE_ADDR <= data_addr < BASE_ADDR+4*DEPTH. Word index = (data_addr-BASE_ADDR)[log2(DEPTH)+1:2].
- FSM states:
  - CLEAR: each cycle writes 32'h0 to word clear_idx, then clear_idx++. After writing word DEPTH-1, go to IDLE.
  - IDLE: mem_ready=1 on the first cycle in IDLE, i.e. exactly DEPTH cycles after rst deasserts. Remains in IDLE until rst.
- In CLEAR:
  - Core writes are dropped.
  - data_out registers 0.
  - err/err_cnt are not updated.
- Write (IDLE, hit): at the rising edge, each lane i with datamem_wr[i]=1 stores data_in<i>. Other lanes are unchanged. No alignment checking; the strobes define the lanes.
- Read (IDLE): every cycle, data_out <= word at index (on hit) or 0 (on miss). Latency is 1 cycle from address to data_out.
- Read/write same word, same cycle: write-first. data_out next cycle shows the merged new word, strobed lanes new and others old.
- Miss (IDLE, out of window):
  - Writes are dropped and data_out <= 0.
  - err=1 for exactly that cycle+1, whether or not strobes are set.
  - err_cnt increments and saturates at 2^ERR_W-1; it does not wrap.
- Address wrap: BASE_ADDR+4*DEPTH computed in 33 bits so a window ending at 2^32 does not wrap.
- Reset mid-CLEAR: restarts from index 0; mem_ready stays 0 for a full DEPTH cycles after release.
- Reset in IDLE: array re-zeroed.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package riscv_mem_pkg:
  - FSM state enum {CLEAR, IDLE}.
  - NUM_LANES=4, LANE_W=8.
  - Default BASE_ADDR/DEPTH constants, also used by the SoC address map.
- Sub-module dmem_lane: one DEPTH x 8 synchronous byte RAM (write enable, write address/data, read address, registered read with write-first). Instantiated 4 times; the top holds the FSM, window decode, error logic and lane-enable muxing (clear vs core).

Test Plan:
- Zero-fill (DEPTH=16): deassert rst at cycle 0 -> mem_ready=0 for cycles 0-15, 1 at cycle 16. Read every word -> 32'h0.
- Full word (DEPTH=16): write 32'hDEADBEEF (strobe 4'b1111) at BASE_ADDR+8, then read BASE_ADDR+8 -> data_out=32'hDEADBEEF one cycle after the read address.
- Byte lane: after the full-word write, write data_in2=8'h55 with strobe 4'b0100 at BASE_ADDR+8 -> read gives 32'hDE55BEEF.
- Same-cycle write/read: hold the address, write strobe 4'b0001 with 8'hAA on a word holding 32'h11223344 -> next-cycle data_out=32'h112233AA.
- Miss: write at BASE_ADDR+64 (DEPTH=16) -> err pulses 1 cycle, err_cnt=1, data_out=0, all words unchanged. 300 misses -> err_cnt=255 (held).
- Reset mid-clear: assert rst at clear_idx=5, release -> mem_ready rises exactly 16 cycles after release. Accesses during CLEAR are ignored; err_cnt stays 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared data-memory definitions for the RV32 load/store path.
// Also supplies the default data window used by the SoC address map.
package riscv_mem_pkg;

    typedef enum logic {
        CLEAR,
        IDLE
    } mem_state_t;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;
    localparam int          DEFAULT_DEPTH     = 1024;

endpackage

// File: rtl/dmem_lane.sv
// One byte lane of the data memory: DEPTH x 8 synchronous RAM.
// Registered read with write-first forwarding; read data is zero when not enabled.
module dmem_lane
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [LANE_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [LANE_W-1:0] o_rdata
);

    logic [LANE_W-1:0] r_mem [DEPTH];
    logic [LANE_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (!i_re) begin
            r_rdata <= '0;
        end else if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 load/store port: zero-fill FSM,
// address window decode, byte-lane muxing and out-of-window error tracking.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter int          ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      data_addr,
    input  logic [3:0]       datamem_wr,
    input  logic [7:0]       data_in0,
    input  logic [7:0]       data_in1,
    input  logic [7:0]       data_in2,
    input  logic [7:0]       data_in3,
    output logic [31:0]      data_out,
    output logic             mem_ready,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);

    mem_state_t       r_state;
    logic [AW-1:0]    r_clr_idx;
    logic             r_ready;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic [32:0]       w_addr33;
    logic [32:0]       w_lo;
    logic [32:0]       w_hi;
    logic              w_hit;
    logic              w_clear;
    logic [31:0]       w_off;
    logic [AW-1:0]     w_idx;
    logic [LANE_W-1:0] w_din [NUM_LANES];
    logic              w_unused;

    // 33-bit compare so a window ending exactly at 2^32 does not wrap
    assign w_addr33 = {1'b0, data_addr};
    assign w_lo     = {1'b0, BASE_ADDR};
    assign w_hi     = w_lo + (33'(DEPTH) << 2);
    assign w_hit    = (w_addr33 >= w_lo) && (w_addr33 < w_hi);

    assign w_off    = data_addr - BASE_ADDR;
    assign w_idx    = w_off[AW+1:2];
    assign w_unused = ^{w_off[31:AW+2], w_off[1:0]};

    assign w_clear  = (r_state == CLEAR);

    assign w_din[0] = data_in0;
    assign w_din[1] = data_in1;
    assign w_din[2] = data_in2;
    assign w_din[3] = data_in3;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_lane #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_clear | (w_hit & datamem_wr[i])),
            .i_waddr (w_clear ? r_clr_idx : w_idx),
            .i_wdata (w_clear ? '0 : w_din[i]),
            .i_re    (!w_clear && w_hit),
            .i_raddr (w_idx),
            .o_rdata (data_out[i*LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (&r_clr_idx) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (!w_hit) begin
                        r_err <= 1'b1;
                        if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign mem_ready = r_ready;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule
